// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and LED patterns for the LED mode controller
package led_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_RUN, MODE_BLINK, MODE_ALL_ON} mode_e;
  localparam logic [3:0] LED_ALL_OFF = 4'b0000;
  localparam logic [3:0] LED_ALL_ON  = 4'b1111;
  localparam logic [3:0] LED_ERR_A   = 4'b1010;
  localparam logic [3:0] LED_ERR_B   = 4'b0101;
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low key into a one-cycle press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  logic sync1, sync2, level, armed, accept;
  logic [1:0] fill;
  logic [CW-1:0] cnt;
  assign accept = (sync2 != level) && (cnt == CNT_LAST);
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fill  <= '0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & sync2 & level);
      cnt   <= (sync2 == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? sync2 : level;
      press <= accept & ~sync2 & armed;
    end
  end
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: key-driven display-mode FSM with error override for the 4-LED bank
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int BLINK_HALF_CYC = 25_000_000,
  parameter int ERR_HALF_CYC   = 5_000_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       err_req,
  input  logic [3:0] run_led,
  output logic       run_vaild,
  output logic [1:0] mode,
  output logic [3:0] led
);
  import led_pkg::*;
  localparam int BW = $clog2(BLINK_HALF_CYC);
  localparam int EW = $clog2(ERR_HALF_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_HALF_CYC - 1);
  mode_e state, state_nxt;
  logic press, err_q, blink_on, blink_act, err_b;
  logic [BW-1:0] blink_cnt;
  logic [EW-1:0] err_cnt;
  logic [3:0] led_nxt;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .press(press)
  );
  always_ff @(posedge sys_clk) begin
    if (!rst_n) state <= MODE_OFF;
    else        state <= state_nxt;
  end
  always_comb state_nxt = (press && !err_q) ? next_mode(state) : state;
  always_comb begin
    mode      = state;
    run_vaild = (state == MODE_RUN) && !err_q;
  end
  assign blink_act = (state == MODE_BLINK) && !err_q;
  always_comb led_nxt = err_q ? (err_b ? LED_ERR_B : LED_ERR_A) :
                        state == MODE_OFF   ? LED_ALL_OFF :
                        state == MODE_RUN   ? run_led :
                        state == MODE_BLINK ? (blink_on ? LED_ALL_ON : LED_ALL_OFF) :
                        LED_ALL_ON;
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      led       <= LED_ALL_OFF;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      err_cnt   <= '0;
      err_b     <= 1'b0;
    end else begin
      err_q     <= err_req;
      led       <= led_nxt;
      blink_cnt <= (!blink_act || blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      blink_on  <= !blink_act ? 1'b1 : (blink_cnt == BLINK_LAST) ? !blink_on : blink_on;
      err_cnt   <= (!err_q || err_cnt == ERR_LAST) ? '0 : err_cnt + 1'b1;
      err_b     <= !err_q ? 1'b0 : (err_cnt == ERR_LAST) ? !err_b : err_b;
    end
  end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed and randomized checks of led_mode_ctrl against a time-based reference model
module tb_led_mode_ctrl;
  localparam int D  = 4;
  localparam int BL = 6;
  localparam int EH = 3;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;
  logic err_req = 1'b0;
  logic [3:0] run_led = 4'b0000;
  logic run_vaild;
  logic [1:0] mode;
  logic [3:0] led;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int press_at = -1;
  int m_mode = 0;
  int err_t0 = 0;
  int blk_t0 = 0;
  logic m_err = 1'b0;
  logic [3:0] m_led = 4'b0000;
  bit rnd = 1'b0;
  led_mode_ctrl #(.DEBOUNCE_CYC(D), .BLINK_HALF_CYC(BL), .ERR_HALF_CYC(EH)) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .err_req(err_req),
    .run_led(run_led),
    .run_vaild(run_vaild),
    .mode(mode),
    .led(led)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    logic e_e, rs_e;
    logic [3:0] r_e;
    bit was_blk;
    e_e = err_req;
    rs_e = rst_n;
    r_e = run_led;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (!rs_e) begin
      m_mode = 0;
      m_err = 1'b0;
      m_led = 4'b0000;
      press_at = -1;
    end else begin
      was_blk = (m_mode == 2) && !m_err;
      m_led = m_err ? ((((cyc - 1 - err_t0) / EH) % 2) != 0 ? 4'b0101 : 4'b1010) :
              m_mode == 0 ? 4'b0000 :
              m_mode == 1 ? r_e :
              m_mode == 2 ? ((((cyc - 1 - blk_t0) / BL) % 2) != 0 ? 4'b0000 : 4'b1111) :
              4'b1111;
      if (press_at == cyc) begin
        if (!m_err) m_mode = (m_mode + 1) % 4;
        press_at = -1;
      end
      if (e_e && !m_err) err_t0 = cyc;
      m_err = e_e;
      if (m_mode == 2 && !m_err && !was_blk) blk_t0 = cyc;
    end
    chk("mode", {2'b00, mode}, 4'(m_mode));
    chk("led", led, m_led);
    chk("run_vaild", {3'b000, run_vaild}, {3'b000, (m_mode == 1) && !m_err});
    if (rnd) run_led = 4'($urandom);
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic press(input int lo, input int hi);
    key_n = 1'b0;
    press_at = cyc + D + 3;
    ticks(lo);
    key_n = 1'b1;
    ticks(hi);
  endtask
  initial begin
    int seq [4];
    seq = '{1, 2, 3, 0};
    rst_n = 1'b0;
    key_n = 1'b0;
    err_req = 1'b1;
    ticks(3);
    chk("rst_mode", {2'b00, mode}, 4'd0);
    chk("rst_led", led, 4'b0000);
    chk("rst_rv", {3'b000, run_vaild}, 4'd0);
    rst_n = 1'b1;
    err_req = 1'b0;
    ticks(20);
    chk("held_key_no_press", {2'b00, mode}, 4'd0);
    key_n = 1'b1;
    ticks(10);
    run_led = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0;
      press_at = cyc + D + 3;
      ticks(6);
      chk("latency_pre", {2'b00, mode}, 4'(i == 0 ? 0 : seq[i-1]));
      tick();
      chk("latency_post", {2'b00, mode}, 4'(seq[i]));
      ticks(13);
      if (i == 0) begin
        chk("run_fwd", led, 4'b0100);
        chk("run_rv", {3'b000, run_vaild}, 4'd1);
      end
      key_n = 1'b1;
      ticks(20);
    end
    key_n = 1'b0;
    ticks(3);
    key_n = 1'b1;
    tick();
    key_n = 1'b0;
    ticks(3);
    key_n = 1'b1;
    ticks(10);
    chk("bounce", {2'b00, mode}, 4'd0);
    press(10, 10);
    chk("after_bounce", {2'b00, mode}, 4'd1);
    key_n = 1'b0;
    press_at = cyc + D + 3;
    ticks(7);
    chk("blink_enter", {2'b00, mode}, 4'd2);
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("blink_pat", led, j < 6 ? 4'b1111 : 4'b0000);
    end
    key_n = 1'b1;
    ticks(10);
    err_req = 1'b1;
    ticks(10);
    err_req = 1'b0;
    ticks(2);
    chk("blink_resume", led, 4'b1111);
    ticks(4);
    chk("blink_resume_on", led, 4'b1111);
    ticks(2);
    chk("blink_resume_off", led, 4'b0000);
    press(20, 20);
    press(20, 20);
    press(20, 20);
    chk("back_to_run", {2'b00, mode}, 4'd1);
    run_led = 4'b0100;
    err_req = 1'b1;
    ticks(2);
    chk("err_a", led, 4'b1010);
    chk("err_rv", {3'b000, run_vaild}, 4'd0);
    ticks(3);
    chk("err_b", led, 4'b0101);
    ticks(3);
    chk("err_a2", led, 4'b1010);
    press(20, 20);
    chk("err_press_hold", {2'b00, mode}, 4'd1);
    err_req = 1'b0;
    ticks(2);
    chk("err_release_rv", {3'b000, run_vaild}, 4'd1);
    chk("err_release_led", led, 4'b0100);
    key_n = 1'b0;
    ticks(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(10);
    chk("midrst_held", {2'b00, mode}, 4'd0);
    key_n = 1'b1;
    ticks(10);
    press(10, 10);
    chk("midrst_press", {2'b00, mode}, 4'd1);
    rnd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1: press($urandom_range(6, 15), $urandom_range(8, 15));
        2: begin
          err_req = 1'b1;
          ticks($urandom_range(1, 12));
          err_req = 1'b0;
          ticks($urandom_range(3, 8));
        end
        default: ticks($urandom_range(1, 10));
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
